sport_responder: RTL and testbench
==================================

SPORT_RESPONDER -- requirements
Module: sport_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of storage depth in 256-bit words (8 = 256 words, 8 KiB).
REQ-002 Parameter RD_LAT, default 4, cycles from accepted read to srdy; legal range 1..15.
REQ-003 Parameter WR_LAT, default 2, cycles from accepted write to srdy; legal range 1..15.
REQ-004 ckdr  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 srd  input  1  read request, one-cycle pulse.
REQ-007 swr  input  1  write request, one-cycle pulse.
REQ-008 sa  input  [33:5]  256-bit word address.
REQ-009 swdat  input  256  write data, byte n = swdat[8n+7:8n].
REQ-010 smsk  input  32  byte mask, bit n = 1 suppresses write of byte n (DDR DM polarity).
REQ-011 srdat  output  256  read data, valid only in the srdy cycle of a read.
REQ-012 srdy  output  1  one-cycle completion pulse for each accepted request.
REQ-013 serr  output  1  sticky protocol-violation flag.

Function
REQ-014 Block SHALL be a drop-in responder for the DDR3 controller's s-port, backed by on-chip RAM, for bring-up of the MCS glue without DDR3.
REQ-015 States SHALL be IDLE, RD_WAIT, WR_WAIT, DONE.
REQ-016 In IDLE, srd=1 with swr=0 SHALL latch sa, load latency counter with RD_LAT-1, and enter RD_WAIT.
REQ-017 In IDLE, swr=1 with srd=0 SHALL latch sa, swdat, smsk, load counter with WR_LAT-1, and enter WR_WAIT.
REQ-018 In IDLE, srd=1 and swr=1 together SHALL be rejected: no state change, no srdy, serr set.
REQ-019 Any srd or swr while not in IDLE SHALL be ignored and SHALL set serr.
REQ-020 RD_WAIT/WR_WAIT SHALL decrement the counter each cycle and go to DONE when it reaches 0.
REQ-021 Memory index SHALL be sa[DEPTH_LOG2+4:5]; upper address bits ignored, so addresses alias modulo 2^DEPTH_LOG2.
REQ-022 Write SHALL commit all unmasked bytes in the cycle WR_WAIT exits; masked bytes retain prior content; smsk=all ones is a legal no-op write that still completes.
REQ-023 Read SHALL sample RAM so that srdat reflects all writes completed before the read was accepted.
REQ-024 DONE SHALL assert srdy for exactly one cycle and return to IDLE the next cycle; a request arriving in the DONE cycle is a violation (REQ-019).
REQ-025 Total latency: srdy high exactly RD_LAT+1 cycles after the srd cycle for reads, WR_LAT+1 after swr for writes.
REQ-026 srdat SHALL hold its last read value until the next read completes; after a write, srdat is unchanged.
REQ-027 serr SHALL stay high until reset.

Reset
REQ-028 With reset=0 at a clock edge: state IDLE, counter 0, srdy 0, serr 0, srdat 0.
REQ-029 Reset mid-transaction SHALL abandon it: no srdy, pending write not committed.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 Shared package SHALL hold s-port widths (address msb 33, lsb 5, data 256, mask 32) and state encodings.
REQ-032 One sub-module sport_ram: single-port, 256-bit wide, 32 byte-enables, synchronous read, 2^DEPTH_LOG2 deep, inferable as block RAM.

Verification
REQ-033 Write sa=0x10, swdat=0x00..1F byte pattern, smsk=0, then read sa=0x10 -> srdy at cycle WR_LAT+1 then RD_LAT+1; srdat equals pattern.
REQ-034 Write all 0xFF, then write all 0x00 with smsk=0xFFFF0000, read -> low 16 bytes 0x00, high 16 bytes 0xFF.
REQ-035 Write sa=0x005 data A, read sa=0x105 (DEPTH_LOG2=8) -> srdat = A (alias).
REQ-036 srd and swr high same cycle in IDLE -> no srdy, serr=1 and stays 1; second srd during RD_WAIT -> exactly one srdy, serr=1.
REQ-037 Assert reset=0 during WR_WAIT of write B to sa=0x20 previously holding A; read sa=0x20 after release -> srdat = A, no srdy during reset, serr=0.
REQ-038 Back-to-back reads issued the cycle after each srdy for 256 random addresses vs. reference model -> all data match, no serr.

Source files
------------

// File: rtl/sport_responder_pkg.sv
// rtl/sport_responder_pkg.sv - s-port widths and responder state encodings
// Shared by sport_responder and sport_ram.
package sport_responder_pkg;

  localparam int SA_MSB = 33;   // word address msb (byte address bit 33)
  localparam int SA_LSB = 5;    // word address lsb (256-bit words)
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;   // one mask bit per data byte
  localparam int CNT_W  = 4;    // holds latencies up to 15

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } sport_state_e;

endpackage

// File: rtl/sport_ram.sv
// rtl/sport_ram.sv - single-port 256-bit RAM with byte enables and synchronous read
// Ports:
//   clk   - clock
//   en    - access enable; with we=0 performs a read into rdata
//   we    - write when en=1; rdata holds its value during writes
//   addr  - word index
//   wdata - write data
//   be    - byte enables, bit n = 1 writes byte n
//   rdata - read data, registered, changes only on reads
module sport_ram
  import sport_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [MASK_W-1:0]     be,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // No reset here: contents survive reset, and rdata stays a plain RAM output.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sport_responder.sv
// rtl/sport_responder.sv - RAM-backed stand-in for the DDR3 controller s-port
// Ports:
//   ckdr  - clock
//   reset - synchronous active-low reset
//   srd   - read request pulse
//   swr   - write request pulse
//   sa    - 256-bit word address (low DEPTH_LOG2 bits used)
//   swdat - write data
//   smsk  - byte mask, 1 = keep old byte
//   srdat - read data, valid in the srdy cycle of a read, held afterwards
//   srdy  - one-cycle completion pulse
//   serr  - sticky protocol-violation flag
module sport_responder
  import sport_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 2
) (
  input  logic                 ckdr,
  input  logic                 reset,
  input  logic                 srd,
  input  logic                 swr,
  input  logic [SA_MSB:SA_LSB] sa,
  input  logic [DATA_W-1:0]    swdat,
  input  logic [MASK_W-1:0]    smsk,
  output logic [DATA_W-1:0]    srdat,
  output logic                 srdy,
  output logic                 serr
);

  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  sport_state_e          state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     wdat_q;
  logic [MASK_W-1:0]     msk_q;

  logic [DEPTH_LOG2-1:0] sa_idx;
  logic                  rd_accept;
  logic                  wr_commit;
  logic                  any_req;
  logic                  ram_en;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;

  // Upper address bits alias; they are deliberately dropped.
  logic unused_sa_hi;
  assign unused_sa_hi = ^sa[SA_MSB:SA_LSB+DEPTH_LOG2];

  assign sa_idx    = sa[SA_LSB+DEPTH_LOG2-1:SA_LSB];
  assign any_req   = srd || swr;
  assign rd_accept = (state == ST_IDLE) && srd && !swr;
  assign wr_commit = (state == ST_WR_WAIT) && (cnt == '0);

  // The RAM is read at the accept edge: no write can land while the read
  // waits, so the word is already final and simply held until DONE.
  // Gating with reset keeps a write that would commit on a reset edge out.
  assign ram_en   = reset && (rd_accept || wr_commit);
  assign ram_addr = (state == ST_IDLE) ? sa_idx : addr_q;

  sport_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (ckdr),
    .en    (ram_en),
    .we    (wr_commit),
    .addr  (ram_addr),
    .wdata (wdat_q),
    .be    (~msk_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge ckdr) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      srdy  <= 1'b0;
      serr  <= 1'b0;
      srdat <= '0;
    end else begin
      srdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (srd && swr) begin
            serr <= 1'b1;
          end else if (srd) begin
            addr_q <= sa_idx;
            cnt    <= RD_CNT;
            state  <= ST_RD_WAIT;
          end else if (swr) begin
            addr_q <= sa_idx;
            wdat_q <= swdat;
            msk_q  <= smsk;
            cnt    <= WR_CNT;
            state  <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (any_req) serr <= 1'b1;
          if (cnt == '0) begin
            state <= ST_DONE;
            srdy  <= 1'b1;
            srdat <= ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (any_req) serr <= 1'b1;
          if (cnt == '0) begin
            state <= ST_DONE;
            srdy  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (any_req) serr <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sport_responder.sv
// tb/tb_sport_responder.sv - directed self-checking bench for sport_responder
module tb_sport_responder;

  localparam int DEPTH_LOG2 = 8;
  localparam int RD_LAT     = 4;
  localparam int WR_LAT     = 2;

  logic          ckdr = 1'b0;
  logic          reset;
  logic          srd;
  logic          swr;
  logic [33:5]   sa;
  logic [255:0]  swdat;
  logic [31:0]   smsk;
  logic [255:0]  srdat;
  logic          srdy;
  logic          serr;

  int tests = 0;
  int fails = 0;

  logic [255:0] model [256];

  sport_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .ckdr  (ckdr),
    .reset (reset),
    .srd   (srd),
    .swr   (swr),
    .sa    (sa),
    .swdat (swdat),
    .smsk  (smsk),
    .srdat (srdat),
    .srdy  (srdy),
    .serr  (serr)
  );

  always #5 ckdr = ~ckdr;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request in cycle 0 and returns the cycle index of srdy.
  task automatic req(input logic rd, input logic wr, input logic [28:0] a,
                     input logic [255:0] d, input logic [31:0] m,
                     output int lat, output logic [255:0] q);
    @(negedge ckdr);
    srd = rd; swr = wr; sa = a; swdat = d; smsk = m;
    @(posedge ckdr);
    lat = -1;
    q   = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge ckdr);
      if (k == 1) begin srd = 1'b0; swr = 1'b0; end
      if (srdy) begin lat = k; q = srdat; break; end
    end
  endtask

  task automatic do_write(input string tag, input logic [28:0] a,
                          input logic [255:0] d, input logic [31:0] m);
    int lat;
    logic [255:0] q;
    req(1'b0, 1'b1, a, d, m, lat, q);
    check({tag, "_wlat"}, 256'(lat), 256'(WR_LAT + 1));
    for (int i = 0; i < 32; i++)
      if (!m[i]) model[a[7:0]][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic do_read(input string tag, input logic [28:0] a, input logic [255:0] exp);
    int lat;
    logic [255:0] q;
    req(1'b1, 1'b0, a, '0, '0, lat, q);
    check({tag, "_rlat"}, 256'(lat), 256'(RD_LAT + 1));
    check({tag, "_data"}, q, exp);
  endtask

  function automatic logic [255:0] pat(input int i);
    return {8{(32'(i) * 32'h9E3779B1) ^ 32'hA5A50000}};
  endfunction

  task automatic count_srdy(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge ckdr);
      if (srdy) c++;
    end
  endtask

  initial begin
    logic [255:0] bytes_pat;
    logic [255:0] val_a;
    logic [255:0] val_b;
    logic [255:0] hold;
    logic [28:0]  ra;
    int           c;

    reset = 1'b0; srd = 1'b0; swr = 1'b0; sa = '0; swdat = '0; smsk = '0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    for (int i = 0; i < 32; i++) bytes_pat[8*i +: 8] = 8'(i);
    val_a = {4{64'h0123_4567_89AB_CDEF}};
    val_b = {4{64'hDEAD_BEEF_CAFE_F00D}};

    // Reset state
    repeat (3) @(negedge ckdr);
    check("rst_srdy", 256'(srdy), 256'(0));
    check("rst_serr", 256'(serr), 256'(0));
    check("rst_srdat", srdat, '0);
    reset = 1'b1;

    // Basic write/read with byte pattern
    do_write("w10", 29'h10, bytes_pat, 32'h0);
    do_read("r10", 29'h10, bytes_pat);
    check("r_after_pat_serr", 256'(serr), 256'(0));

    // srdat unchanged by a subsequent write
    do_write("w11", 29'h11, val_b, 32'h0);
    check("srdat_hold", srdat, bytes_pat);

    // Byte masking, then all-masked no-op write
    do_write("wff", 29'h30, {32{8'hFF}}, 32'h0);
    do_write("wmask", 29'h30, '0, 32'hFFFF0000);
    do_read("rmask", 29'h30, {{16{8'hFF}}, {16{8'h00}}});
    do_write("wnop", 29'h30, val_b, 32'hFFFFFFFF);
    do_read("rnop", 29'h30, {{16{8'hFF}}, {16{8'h00}}});

    // Address aliasing modulo 256 words
    do_write("walias", 29'h005, val_a, 32'h0);
    do_read("ralias", 29'h105, val_a);
    do_read("ralias_hi", 29'h1FFF_FF05, val_a);

    // Simultaneous srd+swr in IDLE is rejected
    @(negedge ckdr); srd = 1'b1; swr = 1'b1; sa = 29'h10;
    @(negedge ckdr); srd = 1'b0; swr = 1'b0;
    count_srdy(10, c);
    check("both_no_srdy", 256'(c), 256'(0));
    check("both_serr", 256'(serr), 256'(1));
    do_read("after_both", 29'h10, bytes_pat);
    check("serr_sticky", 256'(serr), 256'(1));

    // Reset clears serr, not RAM; second srd during RD_WAIT
    @(negedge ckdr); reset = 1'b0;
    @(negedge ckdr); reset = 1'b1;
    check("serr_cleared", 256'(serr), 256'(0));
    @(negedge ckdr); srd = 1'b1; sa = 29'h10;
    @(negedge ckdr); srd = 1'b1;
    @(negedge ckdr); srd = 1'b0;
    hold = srdat;
    c = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge ckdr);
      if (srdy) begin c++; hold = srdat; end
    end
    check("dup_one_srdy", 256'(c), 256'(1));
    check("dup_data", hold, bytes_pat);
    check("dup_serr", 256'(serr), 256'(1));

    // Reset during WR_WAIT abandons the write
    @(negedge ckdr); reset = 1'b0;
    @(negedge ckdr); reset = 1'b1;
    do_write("wA20", 29'h20, val_a, 32'h0);
    @(negedge ckdr); swr = 1'b1; sa = 29'h20; swdat = val_b; smsk = '0;
    @(negedge ckdr); swr = 1'b0; reset = 1'b0;
    c = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ckdr);
      if (srdy) c++;
    end
    reset = 1'b1;
    count_srdy(6, c);
    check("rst_mid_no_srdy", 256'(c), 256'(0));
    check("rst_mid_serr", 256'(serr), 256'(0));
    do_read("rst_mid_r20", 29'h20, val_a);

    // Fill whole RAM, then back-to-back random reads against the model
    for (int i = 0; i < 256; i++) do_write("fill", 29'(i), pat(i), 32'h0);
    for (int i = 0; i < 256; i++) begin
      ra = 29'($urandom_range(0, 32'h1FFF_FFFF));
      do_read("rand", ra, model[ra[7:0]]);
    end
    check("rand_serr", 256'(serr), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
